instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the RV core. It owns the program counter, drives the byte address into the synchronous instruction ROM, and captures the word the ROM returns one cycle later. It then presents a registered {pc, instruction} pair to decode under a valid/stall handshake. Redirects from execute (branches, jumps) are handled here, and a one-entry skid buffer ensures no fetched word is lost or duplicated while decode stalls.

## Interface
- RESET_PC, default 32'h0000_0000: PC fetched first after reset.
- clk  in  1: sole clock; all state updates on rising edge.
- rst  in  1: reset is synchronous and active-high.
- i_stall  in  1: decode cannot accept; hold o_* when o_valid=1.
- i_redirect  in  1: flush and restart fetch at i_redirect_pc.
- i_redirect_pc  in  32: redirect target; bits [1:0] ignored (treated as 0).
- o_rom_addr  out  14: byte address to ROM, combinational; bits [1:0] always 0.
- i_rom_data  in  32: ROM read data, valid exactly one cycle after the address was driven.
- o_valid  out  1: o_pc/o_instr hold a fetched instruction.
- o_pc  out  32: PC of o_instr.
- o_instr  out  32: instruction word.

## Operation
- State:
  - pc_q: next PC to issue.
  - pend_v/pend_pc: request issued last cycle.
  - skid_v/skid_pc/skid_instr: one-entry buffer.
  - Output register: o_valid/o_pc/o_instr.
- Issue condition:
  - issue = !rst && (i_redirect || !(o_valid && i_stall)).
  - issue_pc = i_redirect ? {i_redirect_pc[31:2],2'b00} : pc_q.
  - o_rom_addr = issue_pc[13:0], driven even when not issuing.
  - On issue: pend_v<=1, pend_pc<=issue_pc, pc_q<=issue_pc+4 (32-bit, wraps mod 2^32). Otherwise pend_v<=0 and pc_q holds.
- Return path when not redirecting:
  - advance = !o_valid || !i_stall.
  - If skid_v && advance: output <= skid, skid_v<=0.
  - Else if pend_v && advance: output <= {pend_pc, i_rom_data}.
  - Else if pend_v && !advance: skid <= {pend_pc, i_rom_data}, skid_v<=1.
  - Else if advance: o_valid<=0.
- Invariant: skid_v and pend_v are never both 1. The skid only fills while o_valid&&i_stall, which also blocks issue. Verification asserts this.
- Redirect (highest priority, overrides i_stall):
  - o_valid<=0, skid_v<=0.
  - The in-flight pend word is discarded.
  - The target is issued in the same cycle.
- ROM address is truncated to 14 bits; PC above 0x3FFF aliases in the ROM. o_pc keeps the full 32 bits.
- The ROM's contents beyond its populated range are passed through unchanged (ROM returns 0).

## Timing
- Reset values:
  - pc_q=RESET_PC.
  - pend_v=skid_v=o_valid=0.
  - o_pc=0, o_instr=0.
  - o_rom_addr=RESET_PC[13:0] while rst=1.
  - No issue while rst=1.
- First cycle with rst=0 (call it R): issue RESET_PC. o_valid=1, o_pc=RESET_PC at R+2.
- Steady state: one instruction per cycle; issue-to-o_valid latency 2 cycles.
- Stall: o_* held stable while o_valid&&i_stall. At most one extra word is buffered, in the skid.
  - When i_stall drops, skid data appears next cycle and issue resumes the same cycle.
  - A stall of any length therefore costs no throughput beyond the stall itself.
- Redirect at cycle t:
  - o_valid=0 at t+1.
  - Target instruction valid at t+2.
  - Exactly one bubble cycle.
- Back-to-back redirects: last one wins; each restarts the 2-cycle latency.
- Reset mid-operation (including during stall or with skid full): all valid flags clear next cycle and fetch restarts from RESET_PC.

## Test plan
- ROM model: 1-cycle latency, words 21006093, 0210e113, 00111193, 5681f213, 68a06293 at 0x0–0x10, 0 elsewhere.
- Reset, no stall:
  - Release rst at R -> o_valid rises at R+2.
  - o_pc=0,4,8,C,10,14 on consecutive cycles; o_instr=21006093, 0210e113, 00111193, 5681f213, 68a06293, 00000000.
- Stall mid-stream:
  - Assert i_stall 3 cycles while o_pc=4 -> o_pc=4/o_instr=0210e113 held all 3 cycles.
  - Then 8, C, 10 on consecutive cycles, no gap, no duplicate.
- Redirect:
  - Pulse i_redirect with pc=0x10 while o_pc=4 -> o_valid=0 next cycle.
  - Following cycle o_pc=0x10, o_instr=68a06293; then o_pc=0x14.
- Redirect during stall with skid full:
  - Stall 2 cycles, then redirect to 0x8 with i_stall still high -> skid discarded.
  - o_pc=8/o_instr=00111193 two cycles later; o_pc=0xC never appears from the old stream.
- Misaligned target and wrap:
  - Redirect pc=0x3FFE -> o_pc=0x3FFC, o_rom_addr 0x3FFC.
  - Next o_pc=0x4000 with o_rom_addr=0x0000, o_instr=21006093.
- Reset mid-stream:
  - Assert rst for 1 cycle with i_stall=1 and skid full -> o_valid=0 next cycle.
  - Restart: o_pc=0 two cycles after rst drops.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the synchronous instruction
// ROM, and hands {pc, instruction} pairs to decode under a valid/stall
// handshake. Redirects flush everything in flight, and a one-entry skid
// buffer keeps the word that returns from the ROM while decode is stalled.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [13:0] o_rom_addr,
  input  logic [31:0] i_rom_data,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  // Next PC to issue.
  logic [31:0] pc_q;
  // Request sent to the ROM last cycle; its data is on i_rom_data now.
  logic        pend_v;
  logic [31:0] pend_pc;
  // One-entry buffer for a word that returned while decode was stalled.
  logic        skid_v;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;

  logic        issue;
  logic        advance;
  logic        skid_fill;
  logic [31:0] issue_pc;

  // Word-align a byte address; the low two bits of a target are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  // Issue decision, ROM address and output-register advance.
  always_comb begin
    issue_pc   = i_redirect ? align_word(i_redirect_pc) : pc_q;
    // A redirect always issues; otherwise issue only when the output register
    // is not being held, which also guarantees the skid and the pending
    // request are never occupied together.
    issue      = !rst && (i_redirect || !(o_valid && i_stall));
    advance    = !o_valid || !i_stall;
    skid_fill  = !i_redirect && pend_v && !advance;
    // The ROM only decodes 14 bits; higher PCs alias into it.
    o_rom_addr = rst ? RESET_PC[13:0] : issue_pc[13:0];
  end

  // ---- stage 0: issue to ROM / stage 1: ROM return to output register ----
  // Control flags, PC and the output register (which also has reset values).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pend_v  <= 1'b0;
      skid_v  <= 1'b0;
      o_valid <= 1'b0;
      o_pc    <= 32'd0;
      o_instr <= 32'd0;
    end else begin
      pend_v <= issue;
      if (issue) begin
        pc_q <= issue_pc + 32'd4;
      end

      if (i_redirect) begin
        // Flush: the pending word and any buffered word belong to the old
        // stream and are dropped; the target was issued this cycle.
        o_valid <= 1'b0;
        skid_v  <= 1'b0;
      end else if (skid_v && advance) begin
        o_valid <= 1'b1;
        o_pc    <= skid_pc;
        o_instr <= skid_instr;
        skid_v  <= 1'b0;
      end else if (pend_v && advance) begin
        o_valid <= 1'b1;
        o_pc    <= pend_pc;
        o_instr <= i_rom_data;
      end else if (pend_v) begin
        skid_v  <= 1'b1;
      end else if (advance) begin
        o_valid <= 1'b0;
      end
    end
  end

  // Datapath registers for the in-flight request and the skid entry.
  always_ff @(posedge clk) begin
    if (issue) begin
      pend_pc <= issue_pc;
    end
    if (skid_fill) begin
      skid_pc    <= pend_pc;
      skid_instr <= i_rom_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a driver issues stall/redirect/reset
// stimulus and queues the program-order PC stream the fetch stage must
// deliver; a monitor on the falling edge pops an entry for every word decode
// accepts and checks bubble timing, stall holding and ROM addressing.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [13:0] rom_addr;
  logic [31:0] rom_data = 32'd0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_valid      (valid),
    .o_pc         (pc),
    .o_instr      (instr)
  );

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    case (a)
      14'h0000: return 32'h2100_6093;
      14'h0004: return 32'h0210_e113;
      14'h0008: return 32'h0011_1193;
      14'h000c: return 32'h5681_f213;
      14'h0010: return 32'h68a0_6293;
      default:  return 32'h0000_0000;
    endcase
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected program-order stream of PCs decode will accept.
  logic [31:0] exp_q[$];
  logic [31:0] tail_pc = RPC;

  task automatic sb_flush(input logic [31:0] start);
    exp_q.delete();
    tail_pc = start;
  endtask

  task automatic sb_topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(tail_pc);
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  // Drive one cycle of stimulus and record its effect on the expected stream.
  task automatic cyc(input logic s, input logic r, input logic [31:0] rp, input logic x);
    @(posedge clk);
    #1;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    rst         = x;
    if (x) sb_flush(RPC);
    else if (r) sb_flush(rp & ~32'd3);
    sb_topup();
  endtask

  // Monitor state: cycles of forced bubble still expected, held-output copy.
  int          quiet = 2;
  logic        prev_rst = 1'b0;
  logic        hold_armed = 1'b0;
  logic [31:0] hold_pc = 32'd0;
  logic [31:0] hold_instr = 32'd0;

  always @(negedge clk) begin
    logic [31:0] e;
    checks++;
    if (dut.skid_v && dut.pend_v) begin
      errors++;
      $display("FAIL skid_pend_overlap: skid_v=1 pend_v=1 required not both at %0t", $time);
    end

    chk("o_valid", {31'd0, valid}, {31'd0, (quiet == 0)});
    chk("rom_addr_align", {30'd0, rom_addr[1:0]}, 32'd0);

    if (prev_rst) begin
      chk("reset_o_pc", pc, 32'd0);
      chk("reset_o_instr", instr, 32'd0);
    end

    if (rst) chk("rom_addr_in_reset", {18'd0, rom_addr}, {18'd0, RPC[13:0]});
    else if (redirect) chk("rom_addr_redirect", {18'd0, rom_addr}, {18'd0, redirect_pc[13:2], 2'b00});

    if (hold_armed) begin
      chk("stall_hold_pc", pc, hold_pc);
      chk("stall_hold_instr", instr, hold_instr);
    end

    if (valid && !stall && !rst && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_empty: got pc %h expected no output at %0t", pc, $time);
      end else begin
        e = exp_q.pop_front();
        chk("stream_pc", pc, e);
        chk("stream_instr", instr, rom_word(e[13:0]));
      end
    end

    hold_armed = valid && stall && !rst && !redirect;
    hold_pc    = pc;
    hold_instr = instr;
    prev_rst   = rst;
    if (rst) quiet = 2;
    else if (redirect) quiet = 1;
    else if (quiet > 0) quiet--;
  end

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 40);
      1:       return 32'h0000_3ff0 + $urandom_range(0, 31);
      2:       return 32'hffff_fff0 + $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    sb_flush(RPC);
    sb_topup();
    // Reset, then free-running fetch from RESET_PC.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);
    // Stall for three cycles while pc 4 is presented, then resume.
    repeat (3) cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    // Redirect to 0x10.
    cyc(0, 1, 32'h10, 0);
    repeat (4) cyc(0, 0, 0, 0);
    // Fill the skid, then redirect to 0x8 with stall still high.
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h8, 0);
    repeat (4) cyc(0, 0, 0, 0);
    // Misaligned target near the ROM alias boundary.
    cyc(0, 1, 32'h3ffe, 0);
    repeat (5) cyc(0, 0, 0, 0);
    // Back-to-back redirects: the last wins.
    cyc(0, 1, 32'h4, 0);
    cyc(0, 1, 32'hc, 0);
    repeat (4) cyc(0, 0, 0, 0);
    // PC wrap at 2^32.
    cyc(0, 1, 32'hffff_fffa, 0);
    repeat (4) cyc(0, 0, 0, 0);
    // Reset while stalled with the skid full.
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 2) == 0) || (($urandom_range(0, 40) == 0) && stall),
          $urandom_range(0, 11) == 0, rand_target(), $urandom_range(0, 199) == 0);
    end
    repeat (5) cyc(0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
